core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter row, default 8, PE rows; equals the weight words loaded per kij pass.
REQ-002 Parameter col, default 8, PE columns; sets the post-load settle cycles.
REQ-003 Parameter addr_w, default 11, SRAM address width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-low; asserted when reset==0 at a rising clk edge.
REQ-006 Port start, input, 1: one-cycle request; it is accepted only in IDLE.
REQ-007 Ports w_base, x_base and p_base, input, addr_w each: base addresses for weights, activations and psums.
REQ-008 Port act_len, input, 8: activation words per kij pass, which is also the psum count.
REQ-009 Port kij_num, input, 4: number of kij passes.
REQ-010 Port ofifo_valid, input, 1: the core reports that OFIFO data is available.
REQ-011 Port inst, output, 34: core instruction word, with fields as follows.
- bit 33: acc_en.
- bit 32: cen_pmem.
- bit 31: wen_pmem.
- bits 30:20: a_pmem.
- bit 19: cen_xmem.
- bit 18: wen_xmem.
- bits 17:7: a_xmem.
- bit 6: ofifo_rd.
- bits 5:4: zero.
- bit 3: l0_rd.
- bit 2: l0_wr.
- bit 1: execute.
- bit 0: load.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: one-cycle pulse when a job completes.

Function
REQ-014 All outputs SHALL be registered; CEN and WEN are active-low.
REQ-015 IDLE_INST SHALL be the instruction with both CEN bits and both WEN bits at 1 and all other bits at 0; inst SHALL equal IDLE_INST whenever no field below is asserted.
REQ-016 On start in IDLE, the block SHALL latch all config inputs and set k=0. If act_len==0 or kij_num==0, it SHALL go to DONE with no memory access.
REQ-017 WFETCH (row+1 cycles): in cycle i<row, drive cen_xmem=0, wen_xmem=1, a_xmem=w_base+k*row+i. Assert l0_wr in cycles 1..row to absorb the 1-cycle SRAM read latency.
REQ-018 WLOAD (row cycles): assert l0_rd=1 and load=1.
REQ-019 WSETTLE (col cycles): drive IDLE_INST.
REQ-020 AFETCH (act_len+1 cycles): same pattern as WFETCH, with a_xmem=x_base+k*act_len+i over act_len words.
REQ-021 EXEC (act_len cycles): assert l0_rd=1 and execute=1.
REQ-022 ACC, per psum index j (0..act_len-1), at a_pmem=p_base+j:
- Phase R: held until ofifo_valid==1. Then for one cycle drive ofifo_rd=1; if k>0, also drive cen_pmem=0, wen_pmem=1 (read).
- Phase W (next cycle): drive cen_pmem=0, wen_pmem=0, acc_en=(k>0).
- While ofifo_valid==0, phase R SHALL stall and emit IDLE_INST.
REQ-023 After the last j: if k+1<kij_num, increment k and go to WFETCH; otherwise go to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and inst=IDLE_INST, then return to IDLE.
REQ-025 All address arithmetic SHALL be modulo 2^addr_w (wrap-around).
REQ-026 A start pulse while busy SHALL be ignored, and the latched config SHALL remain unchanged.
REQ-027 FSM states SHALL be IDLE, WFETCH, WLOAD, WSETTLE, AFETCH, EXEC, ACC_R, ACC_W and DONE, with transitions only as stated above.

Reset
REQ-028 While reset==0, at the clock edge the block SHALL set state=IDLE, inst=IDLE_INST, busy=0, done=0, and clear all counters and k.
REQ-029 A reset mid-job SHALL abort the job with no done pulse; a start in the same cycle as reset SHALL be ignored.

Structure
REQ-030 The package core_ctrl_pkg SHALL hold:
- the state enum;
- the inst bit-position constants;
- IDLE_INST.
REQ-031 A sub-module, mem_fetch_seq, is natural: a counter plus the 1-cycle-delayed l0_wr generator, shared by WFETCH and AFETCH.

Verification
REQ-032 Case: kij_num=1, act_len=4, w_base=0, x_base=100, p_base=200.
- Expect a_xmem 0..7 with l0_wr in the following 8 cycles.
- Then 8 load cycles, then 8 settle cycles.
- Then a_xmem 100..103, then 4 execute cycles.
- Then pmem writes to 200..203 with acc_en=0.
- Then one done pulse.
REQ-033 Case: kij_num=2, act_len=2.
- Pass k=1 fetches weights at 8..15 and activations at x_base+2..x_base+3.
- Each pmem read at p_base+j is followed by a write with acc_en=1.
REQ-034 Case: hold ofifo_valid=0 for 5 cycles during ACC_R.
- Expect IDLE_INST for those 5 cycles.
- No ofifo_rd is issued, and j does not advance.
REQ-035 Case: start with act_len=0.
- Expect done=1 one cycle after IDLE, with no CEN low.
- Case: x_base=2046, act_len=4: expect a_xmem 2046, 2047, 0, 1.
REQ-036 Case: reset=0 during EXEC.
- Expect inst=IDLE_INST and busy=0 on the next edge, and no done pulse.
- Case: start pulsed during EXEC: expect it to be ignored.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl shared definitions: state codes, inst bit map, idle word.
// Imported by the controller and its fetch sequencer.
package core_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE    = 4'd0;
   localparam state_t S_WFETCH  = 4'd1;
   localparam state_t S_WLOAD   = 4'd2;
   localparam state_t S_WSETTLE = 4'd3;
   localparam state_t S_AFETCH  = 4'd4;
   localparam state_t S_EXEC    = 4'd5;
   localparam state_t S_ACC_R   = 4'd6;
   localparam state_t S_ACC_W   = 4'd7;
   localparam state_t S_DONE    = 4'd8;

   localparam int INST_W = 34;
   localparam int AF_W   = 11;

   localparam int B_ACC  = 33;
   localparam int B_CENP = 32;
   localparam int B_WENP = 31;
   localparam int B_APH  = 30;
   localparam int B_APL  = 20;
   localparam int B_CENX = 19;
   localparam int B_WENX = 18;
   localparam int B_AXH  = 17;
   localparam int B_AXL  = 7;
   localparam int B_OFRD = 6;
   localparam int B_L0RD = 3;
   localparam int B_L0WR = 2;
   localparam int B_EXEC = 1;
   localparam int B_LOAD = 0;

   localparam logic [INST_W-1:0] IDLE_INST =
      (34'd1 << B_CENP) | (34'd1 << B_WENP) |
      (34'd1 << B_CENX) | (34'd1 << B_WENX);

endpackage

// File: rtl/core_ctrl_fetch.sv
// mem_fetch_seq: xmem read counter plus the one-cycle-late L0 write strobe.
// Shared by the weight and activation fetch phases.
module mem_fetch_seq #(
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run,
   input  logic [addr_w-1:0] i_base,
   input  logic [7:0]        i_len,
   output logic              o_rd,
   output logic              o_wr,
   output logic              o_last,
   output logic [addr_w-1:0] o_addr
);

   logic [7:0] r_cnt;
   logic       r_rd_d;

   assign o_rd   = (r_cnt < i_len);
   assign o_last = (r_cnt == i_len);
   assign o_wr   = r_rd_d;
   assign o_addr = i_base + addr_w'(r_cnt);

   // Count read slots; the delayed read strobe covers SRAM read latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_rd_d <= 1'b0;
      end else begin
         r_cnt  <= (i_run && !o_last) ? r_cnt + 8'd1 : 8'd0;
         r_rd_d <= i_run & o_rd;
      end
   end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: sequences weight load, activation execute and psum accumulate
// over kij passes, emitting one registered core instruction per cycle.
module core_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [addr_w-1:0] w_base,
   input  logic [addr_w-1:0] x_base,
   input  logic [addr_w-1:0] p_base,
   input  logic [7:0]        act_len,
   input  logic [3:0]        kij_num,
   input  logic              ofifo_valid,
   output logic [33:0]       inst,
   output logic              busy,
   output logic              done
);

   localparam logic [7:0]        ROW8  = 8'(row);
   localparam logic [7:0]        COL8  = 8'(col);
   localparam logic [addr_w-1:0] ROW_A = addr_w'(row);

   state_t              r_state;
   logic [7:0]          r_cnt;
   logic [3:0]          r_k;
   logic [addr_w-1:0]   r_wb;
   logic [addr_w-1:0]   r_xb;
   logic [addr_w-1:0]   r_pb;
   logic [7:0]          r_len;
   logic [3:0]          r_kn;

   state_t              w_nstate;
   logic [7:0]          w_ncnt;
   logic [3:0]          w_nk;
   logic [33:0]         w_inst;
   logic                w_done;
   logic                w_wph;
   logic                w_frun;
   logic [addr_w-1:0]   w_fbase;
   logic [7:0]          w_flen;
   logic                w_frd;
   logic                w_fwr;
   logic                w_flast;
   logic [addr_w-1:0]   w_faddr;
   logic [addr_w-1:0]   w_paddr;

   assign w_wph   = (r_state == S_WFETCH);
   assign w_frun  = w_wph || (r_state == S_AFETCH);
   assign w_fbase = w_wph ? r_wb + addr_w'(r_k) * ROW_A
                          : r_xb + addr_w'(r_k) * addr_w'(r_len);
   assign w_flen  = w_wph ? ROW8 : r_len;
   assign w_paddr = r_pb + addr_w'(r_cnt);

   mem_fetch_seq #(.addr_w(addr_w)) u_fetch (
      .clk    (clk),
      .reset  (reset),
      .i_run  (w_frun),
      .i_base (w_fbase),
      .i_len  (w_flen),
      .o_rd   (w_frd),
      .o_wr   (w_fwr),
      .o_last (w_flast),
      .o_addr (w_faddr)
   );

   // Next state, counters and the instruction this state issues.
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nk     = r_k;
      w_inst   = IDLE_INST;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_ncnt   = '0;
               w_nk     = '0;
               w_nstate = (act_len == 8'd0 || kij_num == 4'd0)
                          ? S_DONE : S_WFETCH;
            end
         end
         S_WFETCH, S_AFETCH: begin
            if (w_frd) begin
               w_inst[B_CENX]        = 1'b0;
               w_inst[B_AXH:B_AXL]   = AF_W'(w_faddr);
            end
            w_inst[B_L0WR] = w_fwr;
            if (w_flast) begin
               w_ncnt   = '0;
               w_nstate = w_wph ? S_WLOAD : S_EXEC;
            end
         end
         S_WLOAD: begin
            w_inst[B_L0RD] = 1'b1;
            w_inst[B_LOAD] = 1'b1;
            w_ncnt = r_cnt + 8'd1;
            if (r_cnt == ROW8 - 8'd1) begin
               w_ncnt   = '0;
               w_nstate = S_WSETTLE;
            end
         end
         S_WSETTLE: begin
            w_ncnt = r_cnt + 8'd1;
            if (r_cnt == COL8 - 8'd1) begin
               w_ncnt   = '0;
               w_nstate = S_AFETCH;
            end
         end
         S_EXEC: begin
            w_inst[B_L0RD] = 1'b1;
            w_inst[B_EXEC] = 1'b1;
            w_ncnt = r_cnt + 8'd1;
            if (r_cnt == r_len - 8'd1) begin
               w_ncnt   = '0;
               w_nstate = S_ACC_R;
            end
         end
         S_ACC_R: begin
            if (ofifo_valid) begin
               w_inst[B_OFRD] = 1'b1;
               if (r_k != 4'd0) begin
                  w_inst[B_CENP]      = 1'b0;
                  w_inst[B_APH:B_APL] = AF_W'(w_paddr);
               end
               w_nstate = S_ACC_W;
            end
         end
         S_ACC_W: begin
            w_inst[B_CENP]      = 1'b0;
            w_inst[B_WENP]      = 1'b0;
            w_inst[B_ACC]       = (r_k != 4'd0);
            w_inst[B_APH:B_APL] = AF_W'(w_paddr);
            w_ncnt   = r_cnt + 8'd1;
            w_nstate = S_ACC_R;
            if (r_cnt == r_len - 8'd1) begin
               w_ncnt = '0;
               if ({1'b0, r_k} + 5'd1 < {1'b0, r_kn}) begin
                  w_nk     = r_k + 4'd1;
                  w_nstate = S_WFETCH;
               end else begin
                  w_nstate = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_done   = 1'b1;
            w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   // State, counters, config latch and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
         r_wb    <= '0;
         r_xb    <= '0;
         r_pb    <= '0;
         r_len   <= '0;
         r_kn    <= '0;
         inst    <= IDLE_INST;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_k     <= w_nk;
         inst    <= w_inst;
         busy    <= (w_nstate != S_IDLE);
         done    <= w_done;
         if (r_state == S_IDLE && start) begin
            r_wb  <= w_base;
            r_xb  <= x_base;
            r_pb  <= p_base;
            r_len <= act_len;
            r_kn  <= kij_num;
         end
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: scoreboard of non-idle instructions
// plus job latency, stall, wrap, abort and ignored-start scenarios.
module tb_core_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam logic [33:0] IDLE = 34'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] w_base, x_base, p_base;
   logic [7:0]  act_len;
   logic [3:0]  kij_num;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy, done;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [33:0] q_exp[$];
   logic [33:0] q_obs[$];

   core_ctrl #(.row(ROW), .col(COL), .addr_w(11)) dut (
      .clk(clk), .reset(reset), .start(start),
      .w_base(w_base), .x_base(x_base), .p_base(p_base),
      .act_len(act_len), .kij_num(kij_num),
      .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset === 1'b1 && inst !== IDLE) q_obs.push_back(inst);
      if (done === 1'b1) done_cnt++;
   end

   function automatic int lat_of(input int l, input int kn);
      if (l == 0 || kn == 0) return 2;
      return kn * (2 * ROW + COL + 4 * l + 2) + 2;
   endfunction

   function automatic void push_job(input logic [10:0] wb, input logic [10:0] xb,
                                    input logic [10:0] pb, input int l, input int kn);
      logic [33:0] v;
      if (l == 0 || kn == 0) return;
      for (int k = 0; k < kn; k++) begin
         for (int i = 0; i <= ROW; i++) begin
            v = IDLE;
            if (i < ROW) begin v[19] = 1'b0; v[17:7] = wb + 11'(k * ROW + i); end
            if (i >= 1) v[2] = 1'b1;
            q_exp.push_back(v);
         end
         for (int i = 0; i < ROW; i++) begin
            v = IDLE; v[3] = 1'b1; v[0] = 1'b1; q_exp.push_back(v);
         end
         for (int i = 0; i <= l; i++) begin
            v = IDLE;
            if (i < l) begin v[19] = 1'b0; v[17:7] = xb + 11'(k * l + i); end
            if (i >= 1) v[2] = 1'b1;
            q_exp.push_back(v);
         end
         for (int i = 0; i < l; i++) begin
            v = IDLE; v[3] = 1'b1; v[1] = 1'b1; q_exp.push_back(v);
         end
         for (int j = 0; j < l; j++) begin
            v = IDLE; v[6] = 1'b1;
            if (k > 0) begin v[32] = 1'b0; v[30:20] = pb + 11'(j); end
            q_exp.push_back(v);
            v = IDLE; v[32] = 1'b0; v[31] = 1'b0; v[33] = (k > 0);
            v[30:20] = pb + 11'(j);
            q_exp.push_back(v);
         end
      end
   endfunction

   task automatic kick(input logic [10:0] wb, input logic [10:0] xb,
                       input logic [10:0] pb, input int l, input int kn);
      @(negedge clk);
      q_obs.delete();
      w_base = wb; x_base = xb; p_base = pb;
      act_len = 8'(l); kij_num = 4'(kn); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int c0, input int lim, output int c);
      c = c0;
      while (c <= lim) begin
         @(negedge clk);
         if (done === 1'b1) break;
         c++;
      end
   endtask

   task automatic sb_drain(input string nm);
      logic [33:0] e, o;
      checks++;
      if (q_obs.size() != q_exp.size()) begin
         errors++;
         $display("FAIL %s count got=%0d exp=%0d", nm, q_obs.size(), q_exp.size());
      end
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         o = (q_obs.size() > 0) ? q_obs.pop_front() : 'x;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL %s inst got=%h exp=%h", nm, o, e);
         end
      end
      q_obs.delete();
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
      w_base = '0; x_base = '0; p_base = '0; act_len = '0; kij_num = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (inst !== IDLE) begin errors++; $display("FAIL rst_inst got=%h exp=%h", inst, IDLE); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      reset = 1'b1;
   endtask

   task automatic run_plain(input string nm, input logic [10:0] wb, input logic [10:0] xb,
                            input logic [10:0] pb, input int l, input int kn);
      int c, lat;
      lat = lat_of(l, kn);
      push_job(wb, xb, pb, l, kn);
      kick(wb, xb, pb, l, kn);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got=%b exp=1", nm, busy); end
      wait_done(1, lat + 20, c);
      checks++;
      if (c != lat) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", nm, c, lat); end
      sb_drain(nm);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s after_done done=%b busy=%b exp 0 0", nm, done, busy);
      end
   endtask

   task automatic test_basic;
      run_plain("basic", 11'd0, 11'd100, 11'd200, 4, 1);
   endtask

   task automatic test_multi_kij;
      run_plain("multi_kij", 11'd0, 11'd50, 11'd300, 2, 2);
   endtask

   task automatic test_zero_len;
      run_plain("zero_len", 11'd5, 11'd6, 11'd7, 0, 3);
      run_plain("zero_kij", 11'd5, 11'd6, 11'd7, 5, 0);
   endtask

   task automatic test_wrap;
      run_plain("wrap", 11'd2044, 11'd2046, 11'd2047, 4, 1);
   endtask

   task automatic test_stall;
      int c, p, lat;
      p = 2 * ROW + COL + 2 * 2 + 2;
      lat = lat_of(2, 1) + 5;
      ofifo_valid = 1'b0;
      push_job(11'd0, 11'd100, 11'd300, 2, 1);
      kick(11'd0, 11'd100, 11'd300, 2, 1);
      for (int cy = 1; cy <= p + 7; cy++) begin
         if (cy == p + 6) ofifo_valid = 1'b1;
         @(negedge clk);
         if (cy >= p + 2 && cy <= p + 6) begin
            checks++;
            if (inst !== IDLE) begin
               errors++; $display("FAIL stall_idle cyc=%0d got=%h exp=%h", cy, inst, IDLE);
            end
         end
         if (cy == p + 7) begin
            checks++;
            if (inst[6] !== 1'b1) begin
               errors++; $display("FAIL stall_rd got=%b exp=1", inst[6]);
            end
         end
         @(posedge clk); #1;
      end
      wait_done(p + 8, lat + 20, c);
      checks++;
      if (c != lat) begin errors++; $display("FAIL stall latency got=%0d exp=%0d", c, lat); end
      sb_drain("stall");
   endtask

   task automatic test_ignore_start;
      int c, lat;
      lat = lat_of(2, 1);
      push_job(11'd0, 11'd100, 11'd400, 2, 1);
      kick(11'd0, 11'd100, 11'd400, 2, 1);
      repeat (28) begin @(posedge clk); #1; end
      start = 1'b1; x_base = 11'd500; p_base = 11'd600;
      act_len = 8'd4; kij_num = 4'd2; w_base = 11'd30;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(30, lat + 20, c);
      checks++;
      if (c != lat) begin errors++; $display("FAIL ign_start latency got=%0d exp=%0d", c, lat); end
      sb_drain("ign_start");
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int d0;
      kick(11'd0, 11'd100, 11'd200, 4, 1);
      repeat (31) begin @(posedge clk); #1; end
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      checks++;
      if (inst[1] !== 1'b1) begin errors++; $display("FAIL abort_in_exec got=%b exp=1", inst[1]); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (inst !== IDLE) begin errors++; $display("FAIL abort_inst got=%h exp=%h", inst, IDLE); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      reset = 1'b1; start = 1'b0;
      d0 = done_cnt;
      repeat (60) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got=%b exp=0", busy); end
      q_obs.delete();
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 3; n++) begin
         run_plain("b2b", 11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                   11'($urandom_range(0, 2047)), int'($urandom_range(1, 6)),
                   int'($urandom_range(1, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_kij();
      test_stall();
      test_zero_len();
      test_wrap();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
